// File: rtl/quick_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : quick_spi_pkg
// Description : Shared definitions for blocks that sit in front of the
//               quick_spi master: operation codes, controller state
//               encoding and a slice-index helper for flattened buses.
// Revision    : 1.0 - initial release
// ============================================================================
package quick_spi_pkg;

    // Operation codes carried on req_operation / spi_operation
    localparam logic c_op_read  = 1'b0;
    localparam logic c_op_write = 1'b1;

    // Transaction controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } ctrl_state_e;

    // LSB position of field `index` inside a flattened bus of `width`-bit fields
    function automatic int slice_lsb(input int index, input int width);
        return index * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_rr_arbiter
// Description : Purely combinational round-robin selector. Returns the first
//               set request bit at or after `pointer`, wrapping around.
// Ports       : req          in  N    - request vector
//               pointer      in  clog2(N) - highest-priority position
//               grant_onehot out N    - one-hot winner (zero when none)
//               index        out clog2(N) - winner index
//               valid        out 1    - at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_arbiter #(
    parameter int NUMBER_OF_REQUESTERS = 4
) (
    input  logic [NUMBER_OF_REQUESTERS-1:0]         req,
    input  logic [$clog2(NUMBER_OF_REQUESTERS)-1:0] pointer,
    output logic [NUMBER_OF_REQUESTERS-1:0]         grant_onehot,
    output logic [$clog2(NUMBER_OF_REQUESTERS)-1:0] index,
    output logic                                    valid
);

    localparam int PW = $clog2(NUMBER_OF_REQUESTERS);

    always_comb begin
        int             sum;
        logic [PW-1:0]  cand;
        grant_onehot = '0;
        index        = '0;
        valid        = 1'b0;
        sum          = 0;
        cand         = '0;
        // Walk the ring starting at the pointer; the first hit wins.
        for (int k = 0; k < NUMBER_OF_REQUESTERS; k++) begin
            sum = int'(pointer) + k;
            if (sum >= NUMBER_OF_REQUESTERS) begin
                sum = sum - NUMBER_OF_REQUESTERS;
            end
            cand = PW'(sum);
            if (!valid && req[cand]) begin
                valid              = 1'b1;
                index              = cand;
                grant_onehot[cand] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_transaction_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_transaction_arbiter
// Description : Shares one quick_spi master between N requesters. A
//               round-robin winner is latched in IDLE, the master gets one
//               start pulse, fields are held through BUSY, the read byte and
//               a done pulse go back to the winner, and a GAP state enforces
//               the master's recovery time. A watchdog ends transactions the
//               master never completes, flagging rsp_error.
// Ports       : clk, reset (async, active-high), enable
//               req / req_operation / req_slave / req_outgoing_data  - requesters
//               grant / done / rsp_incoming_data / rsp_error         - responses
//               spi_enable / spi_start_transaction / spi_slave /
//               spi_operation / spi_outgoing_data                    - to master
//               spi_end_of_transaction / spi_incoming_data           - from master
// Revision    : 1.0 - initial release
// ============================================================================
module spi_transaction_arbiter
    import quick_spi_pkg::*;
#(
    parameter int NUMBER_OF_REQUESTERS = 4,
    parameter int NUMBER_OF_SLAVES     = 2,
    parameter int OUTGOING_DATA_WIDTH  = 16,
    parameter int INCOMING_DATA_WIDTH  = 8,
    parameter int GAP_CYCLES           = 1,
    parameter int TIMEOUT_CYCLES       = 4096
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic                                            enable,
    input  logic [NUMBER_OF_REQUESTERS-1:0]                 req,
    input  logic [NUMBER_OF_REQUESTERS-1:0]                 req_operation,
    input  logic [NUMBER_OF_REQUESTERS*NUMBER_OF_SLAVES-1:0]    req_slave,
    input  logic [NUMBER_OF_REQUESTERS*OUTGOING_DATA_WIDTH-1:0] req_outgoing_data,
    output logic [NUMBER_OF_REQUESTERS-1:0]                 grant,
    output logic [NUMBER_OF_REQUESTERS-1:0]                 done,
    output logic [INCOMING_DATA_WIDTH-1:0]                  rsp_incoming_data,
    output logic                                            rsp_error,
    output logic                                            spi_enable,
    output logic                                            spi_start_transaction,
    output logic [NUMBER_OF_SLAVES-1:0]                     spi_slave,
    output logic                                            spi_operation,
    output logic [OUTGOING_DATA_WIDTH-1:0]                  spi_outgoing_data,
    input  logic                                            spi_end_of_transaction,
    input  logic [INCOMING_DATA_WIDTH-1:0]                  spi_incoming_data
);

    localparam int N  = NUMBER_OF_REQUESTERS;
    localparam int NS = NUMBER_OF_SLAVES;
    localparam int OW = OUTGOING_DATA_WIDTH;
    localparam int IW = INCOMING_DATA_WIDTH;
    localparam int PW = $clog2(N);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [TW-1:0] c_timeout_last = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] c_gap_last     = GW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] c_last_index   = PW'(N - 1);

    // ------------------------------------------------------------------
    // Unpack the flattened requester buses
    // ------------------------------------------------------------------
    logic [NS-1:0] slave_arr [N];
    logic [OW-1:0] data_arr  [N];

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign slave_arr[g] = req_slave[slice_lsb(g, NS) +: NS];
        assign data_arr[g]  = req_outgoing_data[slice_lsb(g, OW) +: OW];
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ctrl_state_e   state_q, state_d;
    logic [PW-1:0] winner_q, winner_d;
    logic [PW-1:0] rr_pointer_q, rr_pointer_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  done_q, done_d;
    logic [IW-1:0] rsp_incoming_data_q, rsp_incoming_data_d;
    logic          rsp_error_q, rsp_error_d;
    logic          spi_enable_q, spi_enable_d;
    logic          spi_start_q, spi_start_d;
    logic [NS-1:0] spi_slave_q, spi_slave_d;
    logic          spi_operation_q, spi_operation_d;
    logic [OW-1:0] spi_outgoing_data_q, spi_outgoing_data_d;
    logic [TW-1:0] watchdog_q, watchdog_d;
    logic [GW-1:0] gap_q, gap_d;

    logic [N-1:0]  arb_onehot;
    logic [PW-1:0] arb_index;
    logic          arb_valid;

    spi_rr_arbiter #(
        .NUMBER_OF_REQUESTERS (N)
    ) u_rr_arbiter (
        .req          (req),
        .pointer      (rr_pointer_q),
        .grant_onehot (arb_onehot),
        .index        (arb_index),
        .valid        (arb_valid)
    );

    always_comb begin
        state_d             = state_q;
        winner_d            = winner_q;
        rr_pointer_d        = rr_pointer_q;
        grant_d             = grant_q;
        done_d              = '0;
        rsp_incoming_data_d = rsp_incoming_data_q;
        rsp_error_d         = 1'b0;
        spi_enable_d        = enable;
        spi_start_d         = 1'b0;
        spi_slave_d         = spi_slave_q;
        spi_operation_d     = spi_operation_q;
        spi_outgoing_data_d = spi_outgoing_data_q;
        watchdog_d          = watchdog_q;
        gap_d               = gap_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && arb_valid) begin
                    winner_d            = arb_index;
                    grant_d             = arb_onehot;
                    spi_slave_d         = slave_arr[arb_index];
                    spi_operation_d     = req_operation[arb_index];
                    spi_outgoing_data_d = data_arr[arb_index];
                    spi_start_d         = 1'b1;
                    state_d             = ST_START;
                end
            end
            ST_START: begin
                watchdog_d = '0;
                state_d    = ST_BUSY;
            end
            ST_BUSY: begin
                // End of transaction wins over a watchdog expiring in the same cycle.
                if (spi_end_of_transaction || (watchdog_q == c_timeout_last)) begin
                    done_d              = grant_q;
                    grant_d             = '0;
                    rsp_error_d         = !spi_end_of_transaction;
                    rsp_incoming_data_d = spi_end_of_transaction ? spi_incoming_data : '0;
                    rr_pointer_d        = (winner_q == c_last_index) ? '0 : winner_q + 1'b1;
                    gap_d               = '0;
                    state_d             = ST_GAP;
                end else begin
                    watchdog_d = watchdog_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == c_gap_last) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q             <= ST_IDLE;
            winner_q            <= '0;
            rr_pointer_q        <= '0;
            grant_q             <= '0;
            done_q              <= '0;
            rsp_incoming_data_q <= '0;
            rsp_error_q         <= 1'b0;
            spi_enable_q        <= 1'b0;
            spi_start_q         <= 1'b0;
            spi_slave_q         <= '0;
            spi_operation_q     <= 1'b0;
            spi_outgoing_data_q <= '0;
            watchdog_q          <= '0;
            gap_q               <= '0;
        end else begin
            state_q             <= state_d;
            winner_q            <= winner_d;
            rr_pointer_q        <= rr_pointer_d;
            grant_q             <= grant_d;
            done_q              <= done_d;
            rsp_incoming_data_q <= rsp_incoming_data_d;
            rsp_error_q         <= rsp_error_d;
            spi_enable_q        <= spi_enable_d;
            spi_start_q         <= spi_start_d;
            spi_slave_q         <= spi_slave_d;
            spi_operation_q     <= spi_operation_d;
            spi_outgoing_data_q <= spi_outgoing_data_d;
            watchdog_q          <= watchdog_d;
            gap_q               <= gap_d;
        end
    end

    assign grant                 = grant_q;
    assign done                  = done_q;
    assign rsp_incoming_data     = rsp_incoming_data_q;
    assign rsp_error             = rsp_error_q;
    assign spi_enable            = spi_enable_q;
    assign spi_start_transaction = spi_start_q;
    assign spi_slave             = spi_slave_q;
    assign spi_operation         = spi_operation_q;
    assign spi_outgoing_data     = spi_outgoing_data_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_transaction_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_transaction_arbiter
// Description : Directed bench for spi_transaction_arbiter with a stub SPI
//               master and a scoreboard of expected completions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_transaction_arbiter;
    import quick_spi_pkg::*;

    localparam int N  = 4;
    localparam int NS = 2;
    localparam int OW = 16;
    localparam int IW = 8;

    logic            clk;
    logic            reset;
    logic            enable;
    logic [N-1:0]    req;
    logic [N-1:0]    req_operation;
    logic [N*NS-1:0] req_slave;
    logic [N*OW-1:0] req_outgoing_data;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [IW-1:0]   rsp_incoming_data;
    logic            rsp_error;
    logic            spi_enable;
    logic            spi_start_transaction;
    logic [NS-1:0]   spi_slave;
    logic            spi_operation;
    logic [OW-1:0]   spi_outgoing_data;
    logic            spi_end_of_transaction;
    logic [IW-1:0]   spi_incoming_data;

    spi_transaction_arbiter #(
        .NUMBER_OF_REQUESTERS (N),
        .NUMBER_OF_SLAVES     (NS),
        .OUTGOING_DATA_WIDTH  (OW),
        .INCOMING_DATA_WIDTH  (IW),
        .GAP_CYCLES           (1),
        .TIMEOUT_CYCLES       (32)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .enable                 (enable),
        .req                    (req),
        .req_operation          (req_operation),
        .req_slave              (req_slave),
        .req_outgoing_data      (req_outgoing_data),
        .grant                  (grant),
        .done                   (done),
        .rsp_incoming_data      (rsp_incoming_data),
        .rsp_error              (rsp_error),
        .spi_enable             (spi_enable),
        .spi_start_transaction  (spi_start_transaction),
        .spi_slave              (spi_slave),
        .spi_operation          (spi_operation),
        .spi_outgoing_data      (spi_outgoing_data),
        .spi_end_of_transaction (spi_end_of_transaction),
        .spi_incoming_data      (spi_incoming_data)
    );

    typedef struct {
        logic [N-1:0]  onehot;
        logic [IW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int start_count = 0;
    int t0, at, prev, sc0;

    // Stub master controls
    logic          stub_mute;
    logic          stub_echo;
    int            stub_latency;
    logic [IW-1:0] stub_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stub master: eot comes stub_latency cycles after the start cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (spi_start_transaction === 1'b1 && !stub_mute) begin
                repeat (stub_latency) @(negedge clk);
                spi_incoming_data      = stub_echo ? spi_outgoing_data[7:0] : stub_data;
                spi_end_of_transaction = 1'b1;
                @(negedge clk);
                spi_end_of_transaction = 1'b0;
            end
        end
    end

    // Completion monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (spi_start_transaction === 1'b1) start_count++;
            if (done !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {60'd0, done}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_onehot", {60'd0, done}, {60'd0, mon_e.onehot});
                    check("rsp_data", {56'd0, rsp_incoming_data}, {56'd0, mon_e.data});
                    check("rsp_error", {63'd0, rsp_error}, {63'd0, mon_e.err});
                    check("grant_cleared", {60'd0, grant}, 64'd0);
                end
            end
        end
    end

    task automatic start_req(input logic [N-1:0] bits);
        @(posedge clk);
        #1;
        req = req | bits;
        t0  = cyc;
    endtask

    task automatic wait_done(input int limit, output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < limit; n++) begin
            @(negedge clk);
            if (done !== '0) begin
                at_cyc = cyc;
                return;
            end
        end
        check("done_wait", {63'd0, done !== '0}, 64'd1);
    endtask

    initial begin
        reset                  = 1'b1;
        enable                 = 1'b0;
        req                    = '0;
        req_operation          = 4'b1010;
        req_slave              = '0;
        req_outgoing_data      = '0;
        spi_end_of_transaction = 1'b0;
        spi_incoming_data      = '0;
        stub_mute              = 1'b0;
        stub_echo              = 1'b1;
        stub_latency           = 6;
        stub_data              = '0;
        for (int i = 0; i < N; i++) begin
            req_outgoing_data[i*OW +: OW] = {8'hC0 + 8'(i), 8'h10 + 8'(i)};
            req_slave[i*NS +: NS]         = NS'(i);
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_ctrl", {50'd0, grant, done, rsp_error, spi_enable, spi_start_transaction, spi_operation, spi_slave}, 64'd0);
        check("reset_data", {40'd0, spi_outgoing_data, rsp_incoming_data}, 64'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;

        // Round-robin from pointer 0: order 0,1,2,3 (echoed low data bytes)
        for (int i = 0; i < N; i++) exp_q.push_back('{4'(1 << i), 8'h10 + 8'(i), 1'b0});
        start_req(4'b1111);
        for (int i = 0; i < N; i++) begin
            wait_done(100, at);
            if (i == 0) check("rr_first_latency", 64'(at - t0), 64'd8);
            else        check("rr_spacing", 64'(at - prev), 64'd9);
            prev = at;
            req  = req & ~done;
        end
        // 4'b1001 after serving 3: 0 then 3
        exp_q.push_back('{4'b0001, 8'h10, 1'b0});
        exp_q.push_back('{4'b1000, 8'h13, 1'b0});
        start_req(4'b1001);
        for (int i = 0; i < 2; i++) begin
            wait_done(100, at);
            req = req & ~done;
        end

        // Single read from requester 2
        req_outgoing_data[2*OW +: OW] = 16'hA55A;
        req_operation[2]              = c_op_read;
        req_slave[2*NS +: NS]         = 2'b01;
        stub_echo                     = 1'b0;
        stub_data                     = 8'h3C;
        stub_latency                  = 20;
        exp_q.push_back('{4'b0100, 8'h3C, 1'b0});
        start_req(4'b0100);
        sc0 = start_count;
        @(negedge clk);
        check("grant_cycle0", {60'd0, grant}, 64'd0);
        @(negedge clk);
        check("grant_cycle1", {60'd0, grant}, 64'b0100);
        check("start_cycle1", {63'd0, spi_start_transaction}, 64'd1);
        check("spi_fields", {45'd0, spi_operation, spi_slave, spi_outgoing_data}, {45'd0, c_op_read, 2'b01, 16'hA55A});
        wait_done(100, at);
        check("read_done_latency", 64'(at - t0), 64'd22);
        check("read_one_start", 64'(start_count - sc0), 64'd1);
        req = req & ~done;

        // Field stability: requester 0 changes its fields during BUSY
        req_outgoing_data[0 +: OW] = 16'h1234;
        req_operation[0]           = c_op_write;
        req_slave[0 +: NS]         = 2'b11;
        stub_echo                  = 1'b1;
        stub_latency               = 10;
        exp_q.push_back('{4'b0001, 8'h34, 1'b0});
        start_req(4'b0001);
        sc0 = start_count;
        repeat (3) @(negedge clk);
        req_outgoing_data[0 +: OW] = 16'hFFFF;
        req_operation[0]           = c_op_read;
        req_slave[0 +: NS]         = 2'b00;
        repeat (2) @(negedge clk);
        check("hold_data", {48'd0, spi_outgoing_data}, 64'h1234);
        check("hold_slave_op", {61'd0, spi_operation, spi_slave}, {61'd0, c_op_write, 2'b11});
        wait_done(100, at);
        check("hold_one_start", 64'(start_count - sc0), 64'd1);
        req = req & ~done;

        // Enable drop mid-BUSY
        req_outgoing_data[0 +: OW] = 16'h0042;
        exp_q.push_back('{4'b0001, 8'h42, 1'b0});
        start_req(4'b0001);
        repeat (4) @(negedge clk);
        enable = 1'b0;
        req[1] = 1'b1;
        wait_done(100, at);
        req = req & ~done;
        sc0 = start_count;
        repeat (15) @(negedge clk);
        check("disabled_no_grant", {60'd0, grant}, 64'd0);
        check("disabled_spi_enable", {63'd0, spi_enable}, 64'd0);
        check("disabled_no_start", 64'(start_count - sc0), 64'd0);
        @(posedge clk);
        #1;
        enable = 1'b1;
        exp_q.push_back('{4'b0010, 8'h11, 1'b0});
        @(negedge clk);
        @(negedge clk);
        check("reenable_grant", {60'd0, grant}, 64'b0010);
        wait_done(100, at);
        req = req & ~done;

        // Timeout: master never answers
        stub_mute = 1'b1;
        exp_q.push_back('{4'b1000, 8'h00, 1'b1});
        start_req(4'b1000);
        wait_done(100, at);
        check("timeout_latency", 64'(at - t0), 64'd34);
        req       = req & ~done;
        stub_mute = 1'b0;

        // eot in the same cycle the watchdog expires counts as success
        stub_echo    = 1'b0;
        stub_data    = 8'hE7;
        stub_latency = 32;
        exp_q.push_back('{4'b0100, 8'hE7, 1'b0});
        start_req(4'b0100);
        wait_done(100, at);
        check("eot_at_expiry_latency", 64'(at - t0), 64'd34);
        req = req & ~done;

        // Reset mid-BUSY (pointer is 3 here)
        stub_mute                 = 1'b1;
        req_outgoing_data[OW +: OW] = 16'h5AA5;
        start_req(4'b0010);
        repeat (8) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_ctrl", {50'd0, grant, done, rsp_error, spi_enable, spi_start_transaction, spi_operation, spi_slave}, 64'd0);
        check("midreset_data", {40'd0, spi_outgoing_data, rsp_incoming_data}, 64'd0);
        repeat (3) @(negedge clk);
        check("midreset_no_done", {60'd0, done}, 64'd0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        stub_mute    = 1'b0;
        stub_echo    = 1'b1;
        stub_latency = 5;
        req          = 4'b1010;
        exp_q.push_back('{4'b0010, 8'hA5, 1'b0});
        exp_q.push_back('{4'b1000, 8'h13, 1'b0});
        @(negedge clk);
        @(negedge clk);
        check("postreset_grant", {60'd0, grant}, 64'b0010);
        for (int i = 0; i < 2; i++) begin
            wait_done(100, at);
            req = req & ~done;
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
